// File: rtl/fft_ctrl_pkg.sv
// Shared encodings and helpers for the multimode FFT stage sequencer.
package fft_ctrl_pkg;

    localparam int unsigned MODE_W       = 2;
    localparam int unsigned NSTAGE_W     = 3;
    localparam int unsigned FRAME_CNT_W  = 16;

    localparam logic [MODE_W-1:0] MODE_4PT  = 2'b00;
    localparam logic [MODE_W-1:0] MODE_8PT  = 2'b01;
    localparam logic [MODE_W-1:0] MODE_16PT = 2'b10;
    localparam logic [MODE_W-1:0] MODE_RSVD = 2'b11;

    localparam logic SRC_EXT = 1'b0;
    localparam logic SRC_BF  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LAUNCH,
        ST_WAIT,
        ST_WB,
        ST_DONE
    } state_e;

    // Number of radix-2 stages for a mode; 0 marks an unusable encoding.
    function automatic logic [NSTAGE_W-1:0] mode_stages(input logic [MODE_W-1:0] m);
        case (m)
            MODE_4PT:  return 3'd2;
            MODE_8PT:  return 3'd3;
            MODE_16PT: return 3'd4;
            default:   return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/fft_stage_timer.sv
// Loadable down-counter with a zero flag; times the butterfly pipeline latency.
module fft_stage_timer
    import fft_ctrl_pkg::*;
#(
    parameter int unsigned STAGE_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero_c
);

    localparam int unsigned CNT_W = (STAGE_LAT > 1) ? $clog2(STAGE_LAT) : 1;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= CNT_W'(STAGE_LAT - 1);
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/fft_stage_sequencer.sv
// Sequences the register bank through load, log2(N) butterfly stages and result handoff.
// Optional completed-frame counter enabled by FFT_SEQ_PERF_CNT_EN.
module fft_stage_sequencer
    import fft_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned STAGE_LAT = 2,
    parameter int unsigned STAGE_W   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [MODE_W-1:0]      mode,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic                   abort,
    output logic                   bank_we,
    output logic                   bank_src_sel,
    output logic                   bf_start,
    output logic [STAGE_W-1:0]     stage_idx,
    output logic [NSTAGE_W-1:0]    num_stages,
    output logic                   busy,
    output logic                   done_valid,
    input  logic                   done_ready,
    output logic                   err_mode,
    output logic [FRAME_CNT_W-1:0] frames_done
);

    localparam int unsigned MAX_STAGES = $clog2(DEPTH);

    state_e                state_q, state_d;
    logic                  start_ready_d, busy_d, bank_we_d, bank_src_sel_d;
    logic                  bf_start_d, done_valid_d, err_mode_d;
    logic [STAGE_W-1:0]    stage_idx_d;
    logic [NSTAGE_W-1:0]   num_stages_d;
    logic [NSTAGE_W-1:0]   req_stages_c;
    logic                  mode_ok_c;
    logic                  tmr_load_c, tmr_dec_c, tmr_zero_c;

    // A mode is usable only if it names a size the bank can hold.
    assign req_stages_c = mode_stages(mode);
    assign mode_ok_c    = (req_stages_c != '0) && (req_stages_c <= NSTAGE_W'(MAX_STAGES));

    fft_stage_timer #(
        .STAGE_LAT (STAGE_LAT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load_c),
        .dec    (tmr_dec_c),
        .zero_c (tmr_zero_c)
    );

    // Next state, then registered outputs decoded from the state being entered.
    always_comb begin
        state_d        = state_q;
        start_ready_d  = 1'b0;
        busy_d         = 1'b1;
        bank_we_d      = 1'b0;
        bank_src_sel_d = bank_src_sel;
        bf_start_d     = 1'b0;
        stage_idx_d    = stage_idx;
        num_stages_d   = num_stages;
        done_valid_d   = 1'b0;
        err_mode_d     = 1'b0;
        tmr_load_c     = 1'b0;
        tmr_dec_c      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_valid && start_ready) begin
                    if (!mode_ok_c) begin
                        err_mode_d = 1'b1;
                    end else begin
                        state_d      = ST_LOAD;
                        num_stages_d = req_stages_c;
                        stage_idx_d  = '0;
                    end
                end
            end
            ST_LOAD:   state_d = ST_LAUNCH;
            ST_LAUNCH: begin
                state_d    = ST_WAIT;
                tmr_load_c = 1'b1;
            end
            ST_WAIT: begin
                if (tmr_zero_c) begin
                    state_d = ST_WB;
                end else begin
                    tmr_dec_c = 1'b1;
                end
            end
            ST_WB: begin
                if (NSTAGE_W'(stage_idx) == (num_stages - NSTAGE_W'(1))) begin
                    state_d = ST_DONE;
                end else begin
                    state_d     = ST_LAUNCH;
                    stage_idx_d = stage_idx + STAGE_W'(1);
                end
            end
            ST_DONE: begin
                if (done_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end

        case (state_d)
            ST_IDLE: begin
                start_ready_d = 1'b1;
                busy_d        = 1'b0;
                stage_idx_d   = '0;
            end
            ST_LOAD: begin
                bank_we_d      = 1'b1;
                bank_src_sel_d = SRC_EXT;
            end
            ST_LAUNCH: bf_start_d = 1'b1;
            ST_WB: begin
                bank_we_d      = 1'b1;
                bank_src_sel_d = SRC_BF;
            end
            ST_DONE:   done_valid_d = 1'b1;
            default:   busy_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            start_ready  <= 1'b1;
            busy         <= 1'b0;
            bank_we      <= 1'b0;
            bank_src_sel <= SRC_EXT;
            bf_start     <= 1'b0;
            stage_idx    <= '0;
            num_stages   <= '0;
            done_valid   <= 1'b0;
            err_mode     <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_ready  <= start_ready_d;
            busy         <= busy_d;
            bank_we      <= bank_we_d;
            bank_src_sel <= bank_src_sel_d;
            bf_start     <= bf_start_d;
            stage_idx    <= stage_idx_d;
            num_stages   <= num_stages_d;
            done_valid   <= done_valid_d;
            err_mode     <= err_mode_d;
        end
    end

`ifdef FFT_SEQ_PERF_CNT_EN
    logic                   frame_done_c;
    logic [FRAME_CNT_W-1:0] frames_q;

    // An abort in the handshake cycle wins, so that frame is not counted.
    assign frame_done_c = (state_q == ST_DONE) && done_valid && done_ready && !abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            frames_q <= '0;
        end else if (frame_done_c) begin
            frames_q <= frames_q + FRAME_CNT_W'(1);
        end
    end

    assign frames_done = frames_q;
`else
    assign frames_done = '0;
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed self-checking bench for fft_stage_sequencer (STAGE_LAT=2).
module tb_fft_stage_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        start_valid;
    logic        start_ready;
    logic        abort;
    logic        bank_we;
    logic        bank_src_sel;
    logic        bf_start;
    logic [1:0]  stage_idx;
    logic [2:0]  num_stages;
    logic        busy;
    logic        done_valid;
    logic        done_ready;
    logic        err_mode;
    logic [15:0] frames_done;

    int n_tests = 0;
    int n_fail  = 0;

    fft_stage_sequencer #(
        .DEPTH     (16),
        .STAGE_LAT (2),
        .STAGE_W   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .abort        (abort),
        .bank_we      (bank_we),
        .bank_src_sel (bank_src_sel),
        .bf_start     (bf_start),
        .stage_idx    (stage_idx),
        .num_stages   (num_stages),
        .busy         (busy),
        .done_valid   (done_valid),
        .done_ready   (done_ready),
        .err_mode     (err_mode),
        .frames_done  (frames_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_req(input logic [1:0] m);
        @(negedge clk);
        mode        = m;
        start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
    endtask

    // Strobes are logged at the edge that consumes them (accept edge = 0).
    task automatic run_frame(input string tag, input logic [1:0] m,
                             input logic [63:0] exp_we, input logic [63:0] exp_src,
                             input logic [63:0] exp_bf, input logic [7:0] exp_seq,
                             input int exp_done, input logic [2:0] exp_ns);
        logic [63:0] we_m, src_m, bf_m;
        logic [7:0]  seq;
        int          done_at;
        we_m = '0; src_m = '0; bf_m = '0; seq = '0; done_at = -1;
        @(negedge clk);
        check({tag, " start_ready"}, 64'(start_ready), 64'd1);
        start_req(m);
        for (int n = 0; n < 40 && done_at < 0; n++) begin
            @(negedge clk);
            if (bank_we) begin
                we_m[n+1]  = 1'b1;
                src_m[n+1] = bank_src_sel;
            end
            if (bf_start) begin
                bf_m[n+1] = 1'b1;
                seq       = {seq[5:0], stage_idx};
            end
            if (done_valid) done_at = n;
        end
        check({tag, " done_at"},    64'(done_at),    64'(exp_done));
        check({tag, " bank_we"},    we_m,            exp_we);
        check({tag, " src_sel"},    src_m,           exp_src);
        check({tag, " bf_start"},   bf_m,            exp_bf);
        check({tag, " stage_seq"},  64'(seq),        64'(exp_seq));
        check({tag, " num_stages"}, 64'(num_stages), 64'(exp_ns));
    endtask

    task automatic after_handshake(input string tag);
        @(negedge clk);
        check({tag, " ready_after"}, 64'(start_ready), 64'd1);
        check({tag, " dv_after"},    64'(done_valid),  64'd0);
        check({tag, " busy_after"},  64'(busy),        64'd0);
        check({tag, " stage_after"}, 64'(stage_idx),   64'd0);
    endtask

    task automatic frame_4pt(input string tag);
        run_frame(tag, 2'b00, 64'h222, 64'h220, 64'h44, 8'h01, 9, 3'd2);
        after_handshake(tag);
    endtask

    initial begin
        int quiet;
        rst = 1'b1; mode = 2'b00; start_valid = 1'b0; abort = 1'b0; done_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst start_ready", 64'(start_ready),  64'd1);
        check("rst busy",        64'(busy),         64'd0);
        check("rst bank_we",     64'(bank_we),      64'd0);
        check("rst src_sel",     64'(bank_src_sel), 64'd0);
        check("rst bf_start",    64'(bf_start),     64'd0);
        check("rst stage_idx",   64'(stage_idx),    64'd0);
        check("rst num_stages",  64'(num_stages),   64'd0);
        check("rst done_valid",  64'(done_valid),   64'd0);
        check("rst err_mode",    64'(err_mode),     64'd0);
        check("rst frames_done", 64'(frames_done),  64'd0);

        // 16pt: writes at 1,5,9,13,17; launches at 2,6,10,14; done at 17
        run_frame("16pt", 2'b10, 64'h22222, 64'h22220, 64'h4444, 8'h1B, 17, 3'd4);
        after_handshake("16pt");
        frame_4pt("4pt");
        run_frame("8pt", 2'b01, 64'h2222, 64'h2220, 64'h444, 8'h06, 13, 3'd3);
        after_handshake("8pt");

        // Reserved mode
        start_req(2'b11);
        @(negedge clk);
        check("rsvd err_mode",    64'(err_mode),    64'd1);
        check("rsvd busy",        64'(busy),        64'd0);
        check("rsvd start_ready", 64'(start_ready), 64'd1);
        check("rsvd bank_we",     64'(bank_we),     64'd0);
        check("rsvd num_stages",  64'(num_stages),  64'd3);
        @(negedge clk);
        check("rsvd err_pulse",   64'(err_mode),    64'd0);
        check("rsvd busy2",       64'(busy),        64'd0);

        // Consumer stalls in DONE while a new start is offered
        done_ready = 1'b0;
        run_frame("stall", 2'b00, 64'h222, 64'h220, 64'h44, 8'h01, 9, 3'd2);
        for (int i = 0; i < 5; i++) begin
            check("stall done_valid",  64'(done_valid),  64'd1);
            check("stall start_ready", 64'(start_ready), 64'd0);
            check("stall num_stages",  64'(num_stages),  64'd2);
            mode = 2'b10; start_valid = 1'b1;
            @(negedge clk);
        end
        start_valid = 1'b0; done_ready = 1'b1;
        after_handshake("stall");
        check("stall no_queue", 64'(busy), 64'd0);

        // Abort in WAIT of stage 2 (16pt): state after edge 10 is WAIT
        start_req(2'b10);
        repeat (11) @(negedge clk);
        check("abort pre_stage", 64'(stage_idx), 64'd2);
        check("abort pre_busy",  64'(busy),      64'd1);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort busy",        64'(busy),        64'd0);
        check("abort start_ready", 64'(start_ready), 64'd1);
        check("abort stage_idx",   64'(stage_idx),   64'd0);
        quiet = 0;
        for (int i = 0; i < 10; i++) begin
            if (bank_we || bf_start || done_valid) quiet++;
            @(negedge clk);
        end
        check("abort quiet", 64'(quiet), 64'd0);
        frame_4pt("post_abort");

        // Reset mid-frame
        start_req(2'b01);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst busy",       64'(busy),        64'd0);
        check("midrst start_rdy",  64'(start_ready), 64'd1);
        check("midrst num_stages", 64'(num_stages),  64'd0);
        check("midrst bank_we",    64'(bank_we),     64'd0);

`ifdef FFT_SEQ_PERF_CNT_EN
        for (int i = 0; i < 3; i++) frame_4pt("perf");
        check("perf three", 64'(frames_done), 64'd3);
        start_req(2'b00);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("perf aborted", 64'(frames_done), 64'd3);
        force dut.frames_q = 16'hFFFF;
        @(posedge clk);
        #1 release dut.frames_q;
        frame_4pt("perf_wrap");
        check("perf wrap", 64'(frames_done), 64'd0);
        frame_4pt("perf_one");
        check("perf one", 64'(frames_done), 64'd1);
        start_req(2'b10);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("perf rst", 64'(frames_done), 64'd0);
`else
        check("perf tied", 64'(frames_done), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
Controller that sequences the 16-entry complex register bank through an in-place multimode FFT (4/8/16-point).
- Accepts a start handshake and loads input samples into the bank.
- Steps through log2(N) butterfly stages. Each stage launches the butterfly datapath, waits its fixed latency, then writes results back into the bank.
- Presents completion with a valid/ready handshake.
- Sits between the top-level frame interface and the register bank / butterfly array. It drives the bank write enable and the bank input-source select.

Parameters:
- DEPTH, 16, register bank entries; max FFT size. Power of two.
- STAGE_LAT, 2, butterfly pipeline latency in cycles, >=1.
- STAGE_W, 2, width of stage index, = log2(log2(DEPTH)).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- mode  in  2  FFT size: 00=4pt, 01=8pt, 10=16pt, 11=reserved. Sampled on start accept.
- start_valid  in  1  requester has a frame on the bank input bus
- start_ready  out  1  sequencer idle; can accept
- abort  in  1  synchronous abort of the current transform
- bank_we  out  1  register bank write enable
- bank_src_sel  out  1  bank input mux: 0=external samples, 1=butterfly outputs
- bf_start  out  1  one-cycle launch pulse to the butterfly array
- stage_idx  out  STAGE_W  current stage; selects twiddles/stride
- num_stages  out  3  latched stage count (2/3/4)
- busy  out  1  high in any state other than IDLE
- done_valid  out  1  transform complete; bank holds the result
- done_ready  in  1  consumer has read the bank
- err_mode  out  1  one-cycle pulse when a start is accepted with mode=11
- frames_done  out  16  completed-frame count (see Optional Feature)

Behaviour:
- Reset values: all outputs 0 except start_ready=1. State is IDLE, stage counter 0, latched mode 00.
- FSM states: IDLE, LOAD, LAUNCH, WAIT, WB, DONE.
- IDLE
  - start_ready=1.
  - On start_valid && start_ready, latch mode.
  - mode=11: pulse err_mode; stay IDLE; no bank_we.
  - Otherwise go to LOAD.
- LOAD (1 cycle): bank_we=1, bank_src_sel=0. Next: LAUNCH, with stage_idx=0.
- LAUNCH (1 cycle): bf_start=1. Next: WAIT; timer loaded with STAGE_LAT-1.
- WAIT: held until the timer reaches 0, i.e. STAGE_LAT cycles total. Next: WB.
- WB (1 cycle): bank_we=1, bank_src_sel=1.
  - If stage_idx==num_stages-1, go to DONE.
  - Otherwise stage_idx+1, go to LAUNCH.
- DONE
  - done_valid=1, held stable until done_ready.
  - On done_valid && done_ready, go to IDLE with start_ready=1 in the next cycle. No combinational start_ready from done_ready.
- Latency:
  - out_valid rises 1 + S*(STAGE_LAT+2) cycles after the accept edge.
  - With STAGE_LAT=2: 16pt=17, 8pt=13, 4pt=9 cycles.
- bank_src_sel holds its last value outside LOAD/WB. Its value is only meaningful while bank_we=1.
- stage_idx is 0 in IDLE and holds its final value in DONE.
- Abort:
  - abort in any non-IDLE state forces IDLE next cycle. bank_we is suppressed in the abort cycle; bf_start is not issued.
  - No done_valid, and frames_done is unchanged.
  - abort in IDLE is ignored. abort has priority over done_ready in the same cycle.
- rst mid-transform behaves as abort and also clears all counters.
- start_valid while busy is ignored (start_ready=0). It is never queued.

Optional Feature:
Macro FFT_SEQ_PERF_CNT_EN.
- Defined: frames_done increments on each done handshake and wraps 0xFFFF->0. It is cleared only by rst.
- Undefined: frames_done is tied to 0 and no counter flops exist.

Decomposition:
- Package fft_ctrl_pkg holds:
  - mode encodings (MODE_4PT, MODE_8PT, MODE_16PT, MODE_RSVD)
  - FSM state enum
  - SRC_EXT/SRC_BF constants
  - a function mapping mode to stage count
- One sub-module, fft_stage_timer: a loadable down-counter with a zero flag, parameterised by STAGE_LAT. It is used by the WAIT state.

Test Plan:
- Reset release, mode=10, start pulse, done_ready=1:
  - bank_we high at cycles 1,5,9,13,17 after accept, with src_sel 0,1,1,1,1
  - bf_start at cycles 2,6,10,14
  - done_valid at cycle 17
  - stage_idx sequence 0,1,2,3
- mode=00 and then mode=01: num_stages=2/3; done_valid at cycles 9/13; exactly 3/4 bank_we pulses.
- mode=11 start: err_mode pulses one cycle; busy stays 0; no bank_we; start_ready stays 1.
- done_ready held 0 for 5 cycles in DONE: done_valid stable, start_valid ignored; after handshake, start_ready=1 on the next cycle.
- abort asserted in WAIT of stage 2 (16pt):
  - IDLE next cycle, no further bank_we, no done_valid
  - a new start completes normally with a fresh stage_idx=0
- With FFT_SEQ_PERF_CNT_EN:
  - 3 frames give frames_done=3; one aborted frame leaves it unchanged
  - preloading near wrap (0xFFFF then one frame) gives 0
  - rst mid-frame clears it.
